// File: rtl/lsu_mem_wb.sv
// Osiris I memory stage: data-memory req/gnt/rvalid handshake, lane alignment and MEM/WB register.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and raise o_misalign_W.
module lsu_mem_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   i_alu_result_M,
  input  logic [DATA_WIDTH-1:0]   i_write_data_M,
  input  logic [DATA_WIDTH-1:0]   i_pc_plus4_M,
  input  logic [REG_WIDTH-1:0]    i_rd_M,
  input  logic                    i_reg_write_M,
  input  logic [1:0]              i_result_src_M,
  input  logic                    i_mem_write_M,
  input  logic [2:0]              i_funct3_M,
  output logic                    o_stall_M,
  output logic                    o_dmem_req,
  output logic                    o_dmem_we,
  output logic [DATA_WIDTH-1:0]   o_dmem_addr,
  output logic [DATA_WIDTH-1:0]   o_dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_dmem_be,
  input  logic                    i_dmem_gnt,
  input  logic                    i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_dmem_rdata,
  output logic [DATA_WIDTH-1:0]   o_result_W,
  output logic [REG_WIDTH-1:0]    o_rd_W,
  output logic                    o_reg_write_W,
  output logic                    o_misalign_W
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            r_state;
  logic                  r_req;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_WIDTH-1:0]   r_be;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic                  r_mis;
  logic [DATA_WIDTH-1:0] r_load_data;

  logic [DATA_WIDTH-1:0] r_result_W;
  logic [REG_WIDTH-1:0]  r_rd_W;
  logic                  r_reg_write_W;

  logic                  w_access;
  logic [1:0]            w_off;
  logic                  w_misalign;
  logic [BE_WIDTH-1:0]   w_store_be;
  logic [DATA_WIDTH-1:0] w_store_wdata;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [DATA_WIDTH-1:0] w_load_ext;
  logic [DATA_WIDTH-1:0] w_result_M;
  logic                  w_trap_done;

  assign w_access = i_mem_write_M | (i_result_src_M == 2'b01);
  assign w_off    = i_alu_result_M[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1] set covers the word sizes; funct3[1:0]==01 covers H and HU.
  assign w_misalign = ((i_funct3_M[1:0] == 2'b01) & w_off[0]) |
                      (i_funct3_M[1] & (w_off != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign o_stall_M = ((r_state == IDLE) & w_access) | (r_state == REQ) | (r_state == WAIT);

  // Store lane steering; halfword placement ignores off[0].
  always_comb begin
    w_store_be    = 4'b1111;
    w_store_wdata = i_write_data_M;
    case (i_funct3_M[1:0])
      2'b00: begin
        w_store_be    = 4'b0001 << w_off;
        w_store_wdata = {4{i_write_data_M[7:0]}};
      end
      2'b01: begin
        w_store_be    = 4'b0011 << {w_off[1], 1'b0};
        w_store_wdata = {2{i_write_data_M[15:0]}};
      end
      default: begin
        w_store_be    = 4'b1111;
        w_store_wdata = i_write_data_M;
      end
    endcase
  end

  always_comb begin
    w_rd_byte = i_dmem_rdata[7:0];
    case (r_off)
      2'd0:    w_rd_byte = i_dmem_rdata[7:0];
      2'd1:    w_rd_byte = i_dmem_rdata[15:8];
      2'd2:    w_rd_byte = i_dmem_rdata[23:16];
      default: w_rd_byte = i_dmem_rdata[31:24];
    endcase
    w_rd_half = r_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
  end

  always_comb begin
    w_load_ext = i_dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
      3'b100:  w_load_ext = {24'h000000, w_rd_byte};
      3'b001:  w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
      3'b101:  w_load_ext = {16'h0000, w_rd_half};
      default: w_load_ext = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_mis       <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_funct3 <= i_funct3_M;
            r_off    <= w_off;
            r_mis    <= w_misalign;
            if (w_misalign) begin
              r_state <= DONE;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_we    <= i_mem_write_M;
              r_addr  <= {i_alu_result_M[DATA_WIDTH-1:2], 2'b00};
              r_wdata <= w_store_wdata;
              r_be    <= w_store_be;
            end
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            r_req   <= 1'b0;
            r_state <= r_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (i_dmem_rvalid) begin
            r_load_data <= w_load_ext;
            r_state     <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_mis   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (i_result_src_M)
      2'b01:   w_result_M = r_load_data;
      2'b10:   w_result_M = i_pc_plus4_M;
      default: w_result_M = i_alu_result_M;
    endcase
  end

  assign w_trap_done = (r_state == DONE) & r_mis;

  // Stalled edges inject a bubble; the rest of the W bundle holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_W    <= '0;
      r_rd_W        <= '0;
      r_reg_write_W <= 1'b0;
    end else if (!o_stall_M) begin
      r_result_W    <= w_result_M;
      r_rd_W        <= i_rd_M;
      r_reg_write_W <= i_reg_write_M & ~w_trap_done;
    end else begin
      r_reg_write_W <= 1'b0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_W <= 1'b0;
    end else begin
      r_misalign_W <= w_trap_done;
    end
  end

  assign o_misalign_W = r_misalign_W;
`else
  assign o_misalign_W = 1'b0;
`endif

  assign o_dmem_req    = r_req;
  assign o_dmem_we     = r_we;
  assign o_dmem_addr   = r_addr;
  assign o_dmem_wdata  = r_wdata;
  assign o_dmem_be     = r_be;
  assign o_result_W    = r_result_W;
  assign o_rd_W        = r_rd_W;
  assign o_reg_write_W = r_reg_write_W;

endmodule
